// File: rtl/wb_soc_arbiter_pkg.sv
// Shared Wishbone widths, arbiter FSM encoding and defaults for the SoC bus arbiter.
// Contains package wb_soc_pkg.
package wb_soc_pkg;

   localparam int unsigned WB_ADDR_WIDTH     = 32;
   localparam int unsigned WB_DATA_WIDTH     = 32;
   localparam int unsigned WB_SEL_WIDTH      = WB_DATA_WIDTH / 8;
   localparam int unsigned WB_TIMEOUT_CYCLES = 255;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   function automatic int unsigned wb_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/wb_soc_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the shared slave port.
// Modport slave is the arbiter's view; modport master is the surrounding SoC's view.
interface wb_soc_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 3,
   parameter int unsigned ADDR_WIDTH  = wb_soc_pkg::WB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = wb_soc_pkg::WB_DATA_WIDTH
);
   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

   // master side
   logic [NUM_MASTERS-1:0]            m_cyc_i;
   logic [NUM_MASTERS-1:0]            m_stb_i;
   logic [NUM_MASTERS-1:0]            m_we_i;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
   logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
   logic [DATA_WIDTH-1:0]             m_dat_o;
   logic [NUM_MASTERS-1:0]            m_ack_o;
   logic [NUM_MASTERS-1:0]            m_err_o;

   // slave side
   logic                              s_cyc_o;
   logic                              s_stb_o;
   logic                              s_we_o;
   logic [ADDR_WIDTH-1:0]             s_adr_o;
   logic [DATA_WIDTH-1:0]             s_dat_o;
   logic [SEL_WIDTH-1:0]              s_sel_o;
   logic [DATA_WIDTH-1:0]             s_dat_i;
   logic                              s_ack_i;
   logic                              s_err_i;

   logic [NUM_MASTERS-1:0]            grant_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      input  s_dat_i, s_ack_i, s_err_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output grant_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      output s_dat_i, s_ack_i, s_err_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  grant_o
   );

endinterface

// File: rtl/wb_soc_arbiter_picker.sv
// Combinational round-robin picker: first set request bit above 'last', wrapping.
// Kept generic so the interrupt controller can reuse it.
module rr_priority_picker #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     grant_oh,
   output logic [IDX_W-1:0] grant_idx
);

   always_comb begin
      int unsigned idx;
      logic        found;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned off = 1; off <= N; off++) begin
         idx = (32'(last) + off) % N;
         if (!found && req[idx]) begin
            found         = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_idx     = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/wb_soc_arbiter.sv
// Round-robin Wishbone B3 classic arbiter: one tenure per grant, held while the master's CYC stays high.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_soc_arbiter
   import wb_soc_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 3,
   parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
   input logic             clk_i,
   input logic             rst_n_i,
   wb_soc_arbiter_if.slave bus
);

   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned IDX_W     = $clog2(NUM_MASTERS);

   arb_state_e             state;
   logic [NUM_MASTERS-1:0] grant;
   logic [IDX_W-1:0]       last;
   logic [NUM_MASTERS-1:0] pick_oh;
   logic [IDX_W-1:0]       pick_idx;

   logic                   busy;
   logic                   g_cyc;
   logic                   g_stb;
   logic                   g_we;
   logic [ADDR_WIDTH-1:0]  g_adr;
   logic [DATA_WIDTH-1:0]  g_dat;
   logic [SEL_WIDTH-1:0]   g_sel;
   logic                   tmo_hit;

   rr_priority_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req       (bus.m_cyc_i),
      .last      (last),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx)
   );

   // 'last' doubles as the index of the current grant while BUSY.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ARB_IDLE;
         grant <= '0;
         last  <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|bus.m_cyc_i) begin
                  grant <= pick_oh;
                  last  <= pick_idx;
                  state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (!g_cyc) begin
                  grant <= '0;
                  state <= ARB_IDLE;
               end
            end
            default: begin
               grant <= '0;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == ARB_BUSY);

   // AND-OR mux over the one-hot grant; everything is zero when nothing is granted.
   always_comb begin
      g_cyc = 1'b0;
      g_stb = 1'b0;
      g_we  = 1'b0;
      g_adr = '0;
      g_dat = '0;
      g_sel = '0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (grant[k]) begin
            g_cyc |= bus.m_cyc_i[k];
            g_stb |= bus.m_stb_i[k];
            g_we  |= bus.m_we_i[k];
            g_adr |= bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            g_dat |= bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            g_sel |= bus.m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = wb_max(8, $clog2(TIMEOUT_CYCLES + 1));

   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = busy && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt <= '0;
      end else if (!busy || bus.s_ack_i || bus.s_err_i || tmo_hit) begin
         tmo_cnt <= '0;
      end else if (g_stb) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   logic unused_tmo;

   assign tmo_hit    = 1'b0;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

   assign bus.s_cyc_o = g_cyc & ~tmo_hit;
   assign bus.s_stb_o = g_stb & ~tmo_hit;
   assign bus.s_we_o  = g_we;
   assign bus.s_adr_o = g_adr;
   assign bus.s_dat_o = g_dat;
   assign bus.s_sel_o = g_sel;

   assign bus.m_ack_o = grant & {NUM_MASTERS{bus.s_ack_i}};
   assign bus.m_err_o = grant & {NUM_MASTERS{bus.s_err_i | tmo_hit}};
   assign bus.m_dat_o = busy ? bus.s_dat_i : '0;
   assign bus.grant_o = grant;

endmodule

// File: tb/tb_wb_soc_arbiter.sv
// Directed bench for wb_soc_arbiter: scoreboarded slave-side transfers plus grant/ack/err checks.
module tb_wb_soc_arbiter;

   localparam int unsigned NM  = 3;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;
   localparam int unsigned TMO = 16;

   typedef struct {
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic          we;
      logic [SW-1:0] sel;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        sb[$];

   wb_soc_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   wb_soc_arbiter #(
      .NUM_MASTERS    (NM),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int unsigned k, input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      bus.m_cyc_i[k]            = cyc;
      bus.m_stb_i[k]            = stb;
      bus.m_we_i[k]             = we;
      bus.m_adr_i[k*AW +: AW]   = adr;
      bus.m_dat_i[k*DW +: DW]   = dat;
      bus.m_sel_i[k*SW +: SW]   = '1;
   endtask

   // Entry: arbiter idle and master k requesting. Runs n single-beat transfers, releases, then
   // returns in the dead cycle that follows.
   task automatic tenure(input int unsigned k, input int unsigned n, input logic we,
                         input logic [AW-1:0] abase, input logic [DW-1:0] dbase,
                         input int unsigned ws, input logic [DW-1:0] rdata);
      exp_t          e;
      logic [NM-1:0] oh;
      oh = NM'(1) << k;
      tick();
      check($sformatf("grant_m%0d", k), 64'(bus.grant_o), 64'(oh));
      for (int unsigned i = 0; i < n; i++) begin
         e.adr = abase + AW'(4 * i);
         e.dat = dbase + DW'(i);
         e.we  = we;
         e.sel = '1;
         drive(k, 1'b1, 1'b1, we, e.adr, e.dat);
         sb.push_back(e);
         #1;
         check("s_cyc", 64'(bus.s_cyc_o), 64'(1));
         e = sb.pop_front();
         check("s_adr", 64'(bus.s_adr_o), 64'(e.adr));
         check("s_we", 64'(bus.s_we_o), 64'(e.we));
         check("s_sel", 64'(bus.s_sel_o), 64'(e.sel));
         if (e.we) check("s_dat", 64'(bus.s_dat_o), 64'(e.dat));
         for (int unsigned w = 0; w < ws; w++) begin
            tick();
            check("ack_wait", 64'(bus.m_ack_o), 64'(0));
         end
         bus.s_dat_i = rdata;
         bus.s_ack_i = 1'b1;
         #1;
         check($sformatf("m_ack_m%0d", k), 64'(bus.m_ack_o), 64'(oh));
         if (!e.we) check("m_dat", 64'(bus.m_dat_o), 64'(rdata));
         tick();
         bus.s_ack_i = 1'b0;
         bus.s_dat_i = '0;
      end
      drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("release_s_cyc", 64'(bus.s_cyc_o), 64'(0));
      tick();
      check("dead_cycle_grant", 64'(bus.grant_o), 64'(0));
   endtask

   initial begin
      int unsigned errs;
      errs        = 0;
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i  = '0;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_sel_i = '0;
      bus.s_dat_i = 32'hFFFF_FFFF;
      bus.s_ack_i = 1'b0;
      bus.s_err_i = 1'b0;
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111);
      repeat (3) @(posedge clk);
      #1;

      // reset values, with a master requesting and slave data present
      check("rst_s_cyc", 64'(bus.s_cyc_o), 64'(0));
      check("rst_s_stb", 64'(bus.s_stb_o), 64'(0));
      check("rst_s_adr", 64'(bus.s_adr_o), 64'(0));
      check("rst_grant", 64'(bus.grant_o), 64'(0));
      check("rst_m_ack", 64'(bus.m_ack_o), 64'(0));
      check("rst_m_err", 64'(bus.m_err_o), 64'(0));
      check("rst_m_dat", 64'(bus.m_dat_o), 64'(0));
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      bus.s_dat_i = '0;
      rst_n = 1'b1;

      // single requester, one-cycle arbitration latency
      drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      #1;
      check("latency_s_cyc", 64'(bus.s_cyc_o), 64'(0));
      tenure(1, 1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, '0);

      // contention from a fresh reset: order 0,1,2
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hA000_0000);
      drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'hB000_0000);
      drive(2, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'hC000_0000);
      tenure(0, 2, 1'b1, 32'h0000_1000, 32'hA000_0000, 0, '0);
      tenure(1, 2, 1'b1, 32'h0000_2000, 32'hB000_0000, 1, '0);
      tenure(2, 2, 1'b1, 32'h0000_3000, 32'hC000_0000, 0, '0);

      // fairness: master0 re-requests in the dead cycle while master2 waits
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_0040);
      drive(2, 1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_0050);
      tenure(0, 1, 1'b1, 32'h0000_4000, 32'h0000_0040, 0, '0);
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_4100, 32'h0000_0041);
      tenure(2, 1, 1'b1, 32'h0000_5000, 32'h0000_0050, 0, '0);
      tenure(0, 1, 1'b1, 32'h0000_4100, 32'h0000_0041, 0, '0);

      // read path with three wait states
      drive(2, 1'b1, 1'b1, 1'b0, 32'h2000_0004, '0);
      tenure(2, 1, 1'b0, 32'h2000_0004, '0, 3, 32'h1234_5678);

      // ack and err together, then an abandoned transfer with a late ack
      drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_6000, 32'h0000_0060);
      tick();
      check("ackerr_grant", 64'(bus.grant_o), 64'(3'b010));
      bus.s_ack_i = 1'b1;
      bus.s_err_i = 1'b1;
      #1;
      check("ackerr_ack", 64'(bus.m_ack_o), 64'(3'b010));
      check("ackerr_err", 64'(bus.m_err_o), 64'(3'b010));
      tick();
      bus.s_ack_i = 1'b0;
      bus.s_err_i = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("abandon_s_cyc", 64'(bus.s_cyc_o), 64'(0));
      tick();
      bus.s_ack_i = 1'b1;
      #1;
      check("late_ack", 64'(bus.m_ack_o), 64'(0));
      bus.s_ack_i = 1'b0;

      // asynchronous reset in the middle of master1's tenure
      drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_7000, 32'h0000_0070);
      tick();
      check("pre_rst_grant", 64'(bus.grant_o), 64'(3'b010));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_s_cyc", 64'(bus.s_cyc_o), 64'(0));
      check("async_rst_grant", 64'(bus.grant_o), 64'(0));
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_0080);
      tick();
      check("in_rst_grant", 64'(bus.grant_o), 64'(0));
      rst_n = 1'b1;
      tenure(0, 1, 1'b1, 32'h0000_8000, 32'h0000_0080, 0, '0);
      tenure(1, 1, 1'b1, 32'h0000_7000, 32'h0000_0070, 0, '0);

      // hung slave: master0 strobes and the slave never answers
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_9000, 32'h0000_0090);
      tick();
      check("hang_grant", 64'(bus.grant_o), 64'(3'b001));
      check("hang_s_stb", 64'(bus.s_stb_o), 64'(1));
`ifdef WB_ARB_TIMEOUT_EN
      for (int unsigned c = 1; c <= TMO; c++) begin
         tick();
         if (c < TMO) check("tmo_early_err", 64'(bus.m_err_o), 64'(0));
      end
      check("tmo_err", 64'(bus.m_err_o), 64'(3'b001));
      check("tmo_s_cyc", 64'(bus.s_cyc_o), 64'(0));
      check("tmo_s_stb", 64'(bus.s_stb_o), 64'(0));
      tick();
      check("tmo_err_pulse", 64'(bus.m_err_o), 64'(0));
      check("tmo_grant_kept", 64'(bus.grant_o), 64'(3'b001));
      check("tmo_s_cyc_back", 64'(bus.s_cyc_o), 64'(1));
`else
      for (int unsigned c = 0; c < 1000; c++) begin
         tick();
         if (bus.m_err_o !== '0) errs++;
      end
      check("no_timeout_err", 64'(errs), 64'(0));
      check("hung_s_cyc", 64'(bus.s_cyc_o), 64'(1));
`endif
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      check("final_grant", 64'(bus.grant_o), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_soc_arbiter.md
Name: wb_soc_arbiter

Overview:
- Round-robin Wishbone B3 classic arbiter that shares one slave port between NUM_MASTERS requesters.
- Example requesters: vscale instruction fetch, vscale data port, UART/debug loader.
- Sits in wb_riscv_soc_top between the masters and the SoC interconnect/address decoder.
- Grants one master per bus tenure and holds the grant for as long as that master's CYC stays high, so bursts and read-modify-write sequences are atomic.

Parameters:
- NUM_MASTERS, 3: number of requesting masters (2..8).
- ADDR_WIDTH, 32: Wishbone address width.
- DATA_WIDTH, 32: Wishbone data width. Must be a multiple of 8. SEL width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k occupies slice k.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte selects.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ACK.
- m_err_o  out  NUM_MASTERS  per-master ERR.
- s_cyc_o  out  1  slave-side CYC.
- s_stb_o  out  1  slave-side STB.
- s_we_o  out  1  slave-side WE.
- s_adr_o  out  ADDR_WIDTH  slave-side address.
- s_dat_o  out  DATA_WIDTH  slave-side write data.
- s_sel_o  out  DATA_WIDTH/8  slave-side byte selects.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ACK.
- s_err_i  in  1  slave ERR.
- grant_o  out  NUM_MASTERS  registered one-hot grant (debug/observability).

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - FSM to IDLE, grant_o=0, round-robin pointer last=NUM_MASTERS-1, so master 0 has top priority.
  - All s_* outputs 0; m_ack_o=0; m_err_o=0; m_dat_o=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any m_cyc_i bit is set, select the first requester searching from last+1 upward with wrap.
  - Register its one-hot grant, set last to that index, go to BUSY.
  - No slave signals are driven in IDLE.
  - Arbitration latency: CYC asserted in cycle t gives s_cyc_o high in cycle t+1.
- BUSY:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o = granted master's signals, combinationally gated by grant.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i for the granted master g only; all other bits are 0.
  - m_dat_o=s_dat_i while BUSY, 0 otherwise.
- Release:
  - When m_cyc_i[g] is sampled low in BUSY, go to IDLE and clear the grant.
  - s_cyc_o follows m_cyc_i[g] combinationally, so it drops in the same cycle.
  - Mandatory one dead cycle (IDLE) between tenures; no back-to-back grant.
- Fairness:
  - Master g cannot be re-granted while any other master is requesting at release.
  - Worst-case wait is (NUM_MASTERS-1) tenures plus one dead cycle each.
- Simultaneous requests in IDLE: round-robin order decides; lower index wins only relative to the pointer.
- Granted master drops CYC mid-transfer (before ACK): the transfer is abandoned; a late s_ack_i is not forwarded (grant already cleared next cycle).
- s_ack_i and s_err_i both high: both are forwarded; the master treats ERR as dominant.
- Reset asserted mid-tenure: immediate release, all outputs to reset values, pointer reinitialised.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - 8-bit-or-wider counter (width = clog2(TIMEOUT_CYCLES+1)) increments each BUSY cycle with s_stb_o=1 and s_ack_i=s_err_i=0.
  - Counter clears on ack, err, or leaving BUSY.
  - When the count reaches TIMEOUT_CYCLES: pulse m_err_o[g]=1 for one cycle and force s_cyc_o=s_stb_o=0 in that cycle, then clear the counter.
  - The grant is kept until the master drops CYC.
- Disabled: no counter; m_err_o reflects only s_err_i; a hung slave hangs the bus.

Decomposition:
- Package wb_soc_pkg:
  - Wishbone width constants (WB_ADDR_WIDTH, WB_DATA_WIDTH, WB_SEL_WIDTH).
  - FSM state encoding ARB_IDLE=1'b0, ARB_BUSY=1'b1.
  - Default TIMEOUT_CYCLES.
- Sub-module rr_priority_picker:
  - Purely combinational.
  - Inputs: request vector, last index. Outputs: one-hot next grant, encoded index.
  - Reusable by the future interrupt controller.

Test Plan:
- Single requester: master1 CYC/STB, write adr 0x0000_0010 data 0xDEADBEEF → s_cyc_o high one cycle later; s_adr_o=0x10, s_dat_o=0xDEADBEEF; on slave ack, m_ack_o=3'b010 for one cycle.
- Contention from reset: all three masters raise CYC in the same cycle, each holding for 2 transfers → grant order 0,1,2; one idle cycle between tenures; grant_o sequence 001,010,100.
- Fairness: master0 re-requests immediately after release while master2 is waiting → master2 is granted next, not master0.
- Read path: master2 read at 0x2000_0004, slave returns 0x1234_5678 with ack after 3 wait states → m_dat_o=0x12345678 with m_ack_o[2]=1; m_ack_o[0], m_ack_o[1] stay 0.
- Reset mid-tenure: assert rst_n_i low while master1 is in BUSY → s_cyc_o and grant_o fall to 0 asynchronously (before the next clk_i edge); after release, master0 wins a tie with master1.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: slave never acks → m_err_o[g] pulses exactly 16 cycles after STB, and s_cyc_o is low in that cycle. Without the macro: no err within 1000 cycles.
